// File: rtl/jtag_shift_sequencer.sv
// Turns op/len/data commands into TCK-slot tms/tdi pairs for a JTAG TAP and captures tdo.
// SHIFT_DR is N+5 cycles and SHIFT_IR is N+6 cycles from accept to rsp_valid (+1 from Test-Logic-Reset); a held response blocks new commands.
module jtag_shift_sequencer #(
  parameter int WIDTH = 32,
  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             trst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LW-1:0]    cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_PRE,
    S_SHIFT,
    S_POST,
    S_RUN,
    S_RST
  } state_e;

  localparam logic [1:0] OP_RESET    = 2'b00;
  localparam logic [1:0] OP_RUN      = 2'b01;
  localparam logic [1:0] OP_SHIFT_IR = 2'b10;
  localparam logic [1:0] OP_SHIFT_DR = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic             tlr_q, tlr_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             cmd_accept;
  logic [2:0]       pre_last;

  assign cmd_ready  = (state_q == S_IDLE) && !rsp_valid_q;
  assign cmd_accept = cmd_valid && cmd_ready;
  // IR path needs one extra Select-IR-Scan slot before Capture.
  assign pre_last   = (op_q == OP_SHIFT_IR) ? 3'd3 : 3'd2;

  always_ff @(posedge clk or negedge trst) begin
    if (!trst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      step_q      <= '0;
      tlr_q       <= 1'b1;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      tlr_q       <= tlr_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state: state_q names the slot whose tms/tdi is on the wire this cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    tlr_d       = tlr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          op_d       = cmd_op;
          len_d      = cmd_len;
          data_d     = cmd_data;
          cnt_d      = '0;
          step_d     = '0;
          rsp_data_d = '0;
          if (cmd_op == OP_RESET) begin
            state_d = S_RST;
          end else if (tlr_q) begin
            state_d = S_ENTER;
          end else if (cmd_op == OP_RUN) begin
            state_d = S_RUN;
          end else begin
            state_d = S_PRE;
          end
        end
      end
      S_ENTER: begin
        tlr_d   = 1'b0;
        state_d = (op_q == OP_RUN) ? S_RUN : S_PRE;
      end
      S_PRE: begin
        if (step_q == pre_last) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_SHIFT: begin
        // tdo for slot k is valid at the edge that closes the slot.
        rsp_data_d[cnt_q] = tdo;
        if (cnt_q == len_q) begin
          state_d = S_POST;
          step_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_POST: begin
        if (step_q == 3'd1) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_RUN: begin
        if (cnt_q == len_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RST: begin
        if (step_q == 3'd4) begin
          state_d = S_IDLE;
          tlr_d   = 1'b1;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin values for the slot being entered, so tms/tdi leave straight from flops.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      S_IDLE:  tms_d = tlr_d;
      S_ENTER: tms_d = 1'b0;
      S_PRE: begin
        if (op_d == OP_SHIFT_IR) begin
          tms_d = (step_d <= 3'd1);
        end else begin
          tms_d = (step_d == 3'd0);
        end
      end
      S_SHIFT: begin
        tms_d = (cnt_d == len_d);
        tdi_d = data_d[cnt_d];
      end
      S_POST:  tms_d = (step_d == 3'd0);
      S_RUN:   tms_d = 1'b0;
      S_RST:   tms_d = 1'b1;
      default: tms_d = 1'b0;
    endcase
  end

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// Directed bench for jtag_shift_sequencer: per-slot tms/tdi capture against hand-computed sequences.
module tb_jtag_shift_sequencer;

  logic        clk;
  logic        trst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  logic        tdo_loop;
  logic        tdo_force;

  int checks;
  int failures;

  logic [63:0] tms_log;
  logic [63:0] tdi_log;
  logic [63:0] busy_log;
  logic        rv_any;
  logic        rdy;

  assign tdo = tdo_loop ? tdi : tdo_force;

  jtag_shift_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one command on a negedge; it is taken at the following posedge.
  task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                       output logic ready_seen);
    @(negedge clk);
    ready_seen = cmd_ready;
    cmd_op     = op;
    cmd_len    = len;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic capture(input int n);
    tms_log  = '0;
    tdi_log  = '0;
    busy_log = '0;
    rv_any   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tms_log[i]  = tms;
      tdi_log[i]  = tdi;
      busy_log[i] = busy;
      rv_any      = rv_any | rsp_valid;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (tms !== 1'b1) begin failures++; $display("FAIL reset_tms got=%b exp=1", tms); end
    checks++; if (tdi !== 1'b0) begin failures++; $display("FAIL reset_tdi got=%b exp=0", tdi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    @(posedge clk);
    #1;
    trst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_shift_ir();
    tdo_loop = 1'b1;
    issue(2'b10, 5'd3, 32'h0000000A, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ir_accept got=%b exp=1", rdy); end
    capture(11);
    checks++; if (tms_log[10:0] !== 11'h306) begin failures++; $display("FAIL ir_tms got=%h exp=306", tms_log[10:0]); end
    checks++; if (tdi_log[10:0] !== 11'h140) begin failures++; $display("FAIL ir_tdi got=%h exp=140", tdi_log[10:0]); end
    checks++; if (busy_log[10:0] !== 11'h7FF) begin failures++; $display("FAIL ir_busy got=%h exp=7ff", busy_log[10:0]); end
    checks++; if (rv_any !== 1'b0) begin failures++; $display("FAIL ir_rsp_early got=%b exp=0", rv_any); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ir_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h0000000A) begin failures++; $display("FAIL ir_rsp_data got=%h exp=0000000a", rsp_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ir_idle_busy got=%b exp=0", busy); end
    checks++; if (tms !== 1'b0) begin failures++; $display("FAIL ir_idle_tms got=%b exp=0", tms); end
    release_rsp();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ir_rsp_clear got=%b exp=0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ir_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_shift_dr_full();
    logic [63:0] exp_tdi;
    exp_tdi  = 64'(32'hDEADBEEF) << 3;
    tdo_loop = 1'b1;
    issue(2'b11, 5'd31, 32'hDEADBEEF, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL dr32_accept got=%b exp=1", rdy); end
    capture(37);
    checks++; if (tms_log[36:0] !== 37'h0C_0000_0001) begin failures++; $display("FAIL dr32_tms got=%h exp=0c00000001", tms_log[36:0]); end
    checks++; if (tdi_log[36:0] !== exp_tdi[36:0]) begin failures++; $display("FAIL dr32_tdi got=%h exp=%h", tdi_log[36:0], exp_tdi[36:0]); end
    checks++; if (rv_any !== 1'b0) begin failures++; $display("FAIL dr32_rsp_early got=%b exp=0", rv_any); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL dr32_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL dr32_rsp_data got=%h exp=deadbeef", rsp_data); end
  endtask

  task automatic test_back_to_back_stall();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_rsp_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL stall_cmd_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
      checks++; if (rsp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_rsp_data cyc=%0d got=%h exp=deadbeef", i, rsp_data); end
    end
    release_rsp();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_release_valid got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_run();
    issue(2'b00, 5'd0, 32'h0, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rst_accept got=%b exp=1", rdy); end
    capture(5);
    checks++; if (tms_log[4:0] !== 5'h1F) begin failures++; $display("FAIL rst_tms got=%h exp=1f", tms_log[4:0]); end
    checks++; if (busy_log[4:0] !== 5'h1F) begin failures++; $display("FAIL rst_busy got=%h exp=1f", busy_log[4:0]); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_done_busy got=%b exp=0", busy); end
    checks++; if (tms !== 1'b1) begin failures++; $display("FAIL rst_hold_tms got=%b exp=1", tms); end
    issue(2'b01, 5'd2, 32'h0, rdy);
    capture(4);
    checks++; if (tms_log[3:0] !== 4'h0) begin failures++; $display("FAIL run_tms got=%h exp=0", tms_log[3:0]); end
    checks++; if (busy_log[3:0] !== 4'hF) begin failures++; $display("FAIL run_busy got=%h exp=f", busy_log[3:0]); end
    checks++; if (rv_any !== 1'b0) begin failures++; $display("FAIL run_rsp got=%b exp=0", rv_any); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_done_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL run_done_rsp got=%b exp=0", rsp_valid); end
    checks++; if (tms !== 1'b0) begin failures++; $display("FAIL run_idle_tms got=%b exp=0", tms); end
  endtask

  task automatic test_abort();
    tdo_loop = 1'b1;
    issue(2'b11, 5'd7, 32'h000000FF, rdy);
    capture(7);
    checks++; if (tms_log[6:0] !== 7'h01) begin failures++; $display("FAIL abort_pre_tms got=%h exp=01", tms_log[6:0]); end
    #1;
    trst = 1'b0;
    #1;
    checks++; if (tms !== 1'b1) begin failures++; $display("FAIL abort_tms got=%b exp=1", tms); end
    checks++; if (tdi !== 1'b0) begin failures++; $display("FAIL abort_tdi got=%b exp=0", tdi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL abort_rsp_data got=%h exp=0", rsp_data); end
    @(posedge clk);
    #1;
    trst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_stays_idle got=%b exp=0", busy); end
    tdo_loop  = 1'b0;
    tdo_force = 1'b1;
    issue(2'b11, 5'd0, 32'hFFFFFFFE, rdy);
    capture(7);
    checks++; if (tms_log[6:0] !== 7'h32) begin failures++; $display("FAIL enter_dr1_tms got=%h exp=32", tms_log[6:0]); end
    checks++; if (tdi_log[6:0] !== 7'h00) begin failures++; $display("FAIL enter_dr1_tdi got=%h exp=00", tdi_log[6:0]); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL enter_dr1_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h00000001) begin failures++; $display("FAIL enter_dr1_rsp_data got=%h exp=00000001", rsp_data); end
    release_rsp();
  endtask

  task automatic test_shift_dr_n1();
    tdo_loop  = 1'b0;
    tdo_force = 1'b1;
    issue(2'b11, 5'd0, 32'hFFFFFFFE, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL dr1_accept got=%b exp=1", rdy); end
    capture(6);
    checks++; if (tms_log[5:0] !== 6'h19) begin failures++; $display("FAIL dr1_tms got=%h exp=19", tms_log[5:0]); end
    checks++; if (tdi_log[5:0] !== 6'h00) begin failures++; $display("FAIL dr1_tdi got=%h exp=00", tdi_log[5:0]); end
    checks++; if (rv_any !== 1'b0) begin failures++; $display("FAIL dr1_rsp_early got=%b exp=0", rv_any); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL dr1_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h00000001) begin failures++; $display("FAIL dr1_rsp_data got=%h exp=00000001", rsp_data); end
    release_rsp();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL dr1_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    trst      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 5'd0;
    cmd_data  = 32'h0;
    rsp_ready = 1'b0;
    tdo_loop  = 1'b1;
    tdo_force = 1'b0;

    test_reset();
    test_shift_ir();
    test_shift_dr_full();
    test_back_to_back_stall();
    test_reset_run();
    test_abort();
    test_shift_dr_n1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
